// File: rtl/sysmgr_rst_seq.sv
// sysmgr_rst_seq
// PLL bring-up and staged reset sequencer for the system clock manager.
// It holds the PLL in reset and then waits for a stable lock, retrying when
// lock does not arrive in time. After that it releases rst_early first and
// rst_late a fixed gap later. The whole block runs on the free-running
// reference clock.
//
// Ports
//   clk         in   reference clock, free-running
//   rst         in   synchronous active-high reset
//   pll_lock    in   PLL LOCK, asynchronous to clk (synchronised here)
//   restart     in   single-cycle request to re-run the whole sequence
//   clr_status  in   clears lock_lost and retry_cnt
//   pll_resetb  out  PLL RESETB, active-low
//   rst_early   out  reset request for SERDES/QPI/CRG, active-high
//   rst_late    out  reset request for main logic, active-high
//   ready       out  sequence complete, PLL locked
//   lock_lost   out  sticky: lock dropped after release began
//   retry_cnt   out  lock-timeout retries, saturating at 15
module sysmgr_rst_seq #(
   parameter int unsigned RESET_HOLD   = 16,
   parameter int unsigned LOCK_TIMEOUT = 4096,
   parameter int unsigned LOCK_STABLE  = 256,
   parameter int unsigned STAGE_GAP    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_lock,
   input  logic       restart,
   input  logic       clr_status,
   output logic       pll_resetb,
   output logic       rst_early,
   output logic       rst_late,
   output logic       ready,
   output logic       lock_lost,
   output logic [3:0] retry_cnt
);

   // One shared counter is used. It must be wide enough for the longest interval.
   localparam int unsigned MAX_AB = (RESET_HOLD  > LOCK_TIMEOUT) ? RESET_HOLD  : LOCK_TIMEOUT;
   localparam int unsigned MAX_CD = (LOCK_STABLE > STAGE_GAP)    ? LOCK_STABLE : STAGE_GAP;
   localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   localparam logic [CW-1:0] HOLD_END    = CW'(RESET_HOLD - 1);
   localparam logic [CW-1:0] TIMEOUT_END = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_END  = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] GAP_END     = CW'(STAGE_GAP - 1);

   typedef enum logic [2:0] {
      HOLD,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          lock_meta;
   logic          lock_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HOLD;
         cnt        <= '0;
         lock_meta  <= 1'b0;
         lock_s     <= 1'b0;
         lock_lost  <= 1'b0;
         retry_cnt  <= '0;
         pll_resetb <= 1'b0;
         rst_early  <= 1'b1;
         rst_late   <= 1'b1;
         ready      <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;

         // Outputs decode the state register itself, so they settle one clock
         // after the state changes. They are glitch-free and all change together.
         pll_resetb <= (state != HOLD);
         rst_early  <= (state == HOLD) || (state == WAIT_LOCK) || (state == STABLE);
         rst_late   <= (state != RUN);
         ready      <= (state == RUN);

         // The clear is written first. Any set or increment further down in the
         // same clock overrides it.
         if (clr_status) begin
            lock_lost <= 1'b0;
            retry_cnt <= '0;
         end

         cnt <= cnt + 1'b1;

         if (restart) begin
            state <= HOLD;
            cnt   <= '0;
         end else begin
            case (state)
               HOLD: begin
                  if (cnt == HOLD_END) begin
                     state <= WAIT_LOCK;
                     cnt   <= '0;
                  end
               end
               WAIT_LOCK: begin
                  if (lock_s) begin
                     state <= STABLE;
                     cnt   <= '0;
                  end else if (cnt == TIMEOUT_END) begin
                     state     <= HOLD;
                     cnt       <= '0;
                     retry_cnt <= (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
                  end
               end
               STABLE: begin
                  if (!lock_s) begin
                     state <= WAIT_LOCK;
                     cnt   <= '0;
                  end else if (cnt == STABLE_END) begin
                     state <= RELEASE;
                     cnt   <= '0;
                  end
               end
               RELEASE: begin
                  if (!lock_s) begin
                     state     <= HOLD;
                     cnt       <= '0;
                     lock_lost <= 1'b1;
                  end else if (cnt == GAP_END) begin
                     state <= RUN;
                     cnt   <= '0;
                  end
               end
               RUN: begin
                  if (!lock_s) begin
                     state     <= HOLD;
                     cnt       <= '0;
                     lock_lost <= 1'b1;
                  end
               end
               default: begin
                  state <= HOLD;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sysmgr_rst_seq.sv
// Testbench for sysmgr_rst_seq. It uses a scoreboard of expected output transitions.
// The stimulus pushes (cycle, output vector) events that were worked out by hand.
// A monitor pops one event each time the outputs change, and it also pops one
// at every reset release. Cycle 0 is the first edge with rst=0.
// Output vector: {pll_resetb, rst_early, rst_late, ready, lock_lost, retry_cnt}.
module tb_sysmgr_rst_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_lock = 1'b0;
   logic       restart = 1'b0;
   logic       clr_status = 1'b0;
   logic       pll_resetb;
   logic       rst_early;
   logic       rst_late;
   logic       ready;
   logic       lock_lost;
   logic [3:0] retry_cnt;

   sysmgr_rst_seq #(
      .RESET_HOLD   (4),
      .LOCK_TIMEOUT (20),
      .LOCK_STABLE  (8),
      .STAGE_GAP    (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_lock   (pll_lock),
      .restart    (restart),
      .clr_status (clr_status),
      .pll_resetb (pll_resetb),
      .rst_early  (rst_early),
      .rst_late   (rst_late),
      .ready      (ready),
      .lock_lost  (lock_lost),
      .retry_cnt  (retry_cnt)
   );

   always #5 clk = ~clk;

   // {pll_resetb, rst_early, rst_late, ready} for each phase of the sequence
   localparam logic [3:0] HOLDV = 4'b0110;
   localparam logic [3:0] WAITV = 4'b1110;  // WAIT_LOCK and STABLE look alike
   localparam logic [3:0] RELV  = 4'b1010;
   localparam logic [3:0] RUNV  = 4'b1001;

   typedef struct {
      int         cyc;
      logic [8:0] vec;
      string      tag;
   } ev_t;

   ev_t exp_q[$];
   ev_t e;

   int tests = 0;
   int fails = 0;
   int cyc   = -1;

   always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

   function automatic void exp_ev(input int c, input logic [3:0] o, input logic ll,
                                  input logic [3:0] rc, input string tag);
      ev_t n;
      n.cyc = c;
      n.vec = {o, ll, rc};
      n.tag = tag;
      exp_q.push_back(n);
   endfunction

   // Monitor
   logic [8:0] prev = 'x;
   logic [8:0] cur;
   always @(negedge clk) begin
      cur = {pll_resetb, rst_early, rst_late, ready, lock_lost, retry_cnt};
      if (!rst && (cyc == -1 || cur !== prev)) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change: cycle %0d outputs %b, required no change", cyc, cur);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || cur !== e.vec) begin
               fails++;
               $display("FAIL %s: cycle %0d outputs %b, required cycle %0d outputs %b",
                        e.tag, cyc, cur, e.cyc, e.vec);
            end
         end
      end
      prev = cur;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns 1 time unit after edge n. Inputs set then are sampled at edge n+1.
   task automatic goto(input int n);
      while (cyc < n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_missing: %0d expected events outstanding, required 0 (next: %s at cycle %0d)",
                  name, exp_q.size(), exp_q[0].tag, exp_q[0].cyc);
      end
      exp_q.delete();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc;
      int base;

      // Run 1: lock high from reset. Then lock is lost in RUN, then there is a
      // restart in RELEASE, then a clear.
      exp_ev(-1, HOLDV, 1'b0, 4'd0, "r1_reset");
      exp_ev( 4, WAITV, 1'b0, 4'd0, "r1_resetb_rise");
      exp_ev(13, RELV,  1'b0, 4'd0, "r1_early_fall");
      exp_ev(16, RUNV,  1'b0, 4'd0, "r1_late_fall_ready");
      exp_ev(23, RUNV,  1'b1, 4'd0, "r1_lock_lost_set_beats_clr");
      exp_ev(24, HOLDV, 1'b1, 4'd0, "r1_resets_reassert");
      exp_ev(28, WAITV, 1'b1, 4'd0, "r1_relock_resetb");
      exp_ev(42, RELV,  1'b1, 4'd0, "r1_relock_early_fall");
      exp_ev(43, HOLDV, 1'b1, 4'd0, "r1_restart_hold");
      exp_ev(47, WAITV, 1'b1, 4'd0, "r1_restart_resetb");
      exp_ev(56, RELV,  1'b1, 4'd0, "r1_restart_early_fall");
      exp_ev(59, RUNV,  1'b1, 4'd0, "r1_restart_ready");
      exp_ev(66, RUNV,  1'b0, 4'd0, "r1_clr_lock_lost");
      pll_lock = 1'b1;
      do_reset();
      goto(20); pll_lock = 1'b0;
      goto(22); clr_status = 1'b1;
      goto(23); clr_status = 1'b0;
      goto(30); pll_lock = 1'b1;
      goto(41); restart = 1'b1;
      goto(42); restart = 1'b0;
      goto(65); clr_status = 1'b1;
      goto(66); clr_status = 1'b0;
      goto(72);
      drain("r1");

      // Run 2: lock never arrives. Retries are counted, clear and increment
      // collide, and the counter saturates at 15.
      exp_ev(-1, HOLDV, 1'b0, 4'd0, "r2_reset");
      exp_ev( 4, WAITV, 1'b0, 4'd0, "r2_resetb_rise");
      exp_ev(23, WAITV, 1'b0, 4'd1, "r2_retry1_with_clr");
      exp_ev(24, HOLDV, 1'b0, 4'd1, "r2_retry1_hold");
      exp_ev(28, WAITV, 1'b0, 4'd1, "r2_retry1_resetb");
      exp_ev(47, WAITV, 1'b0, 4'd2, "r2_retry2_inc_beats_clr");
      exp_ev(48, HOLDV, 1'b0, 4'd0, "r2_clr_next_clock");
      exp_ev(52, WAITV, 1'b0, 4'd0, "r2_resetb_after_clr");
      for (int k = 1; k <= 17; k++) begin
         rc   = (k > 15) ? 15 : k;
         base = 71 + 24 * (k - 1);
         if (k <= 15) exp_ev(base, WAITV, 1'b0, 4'(rc), "r2_retry_count");
         exp_ev(base + 1, HOLDV, 1'b0, 4'(rc), "r2_retry_hold");
         exp_ev(base + 5, WAITV, 1'b0, 4'(rc), "r2_retry_resetb");
      end
      pll_lock = 1'b0;
      do_reset();
      goto(22); clr_status = 1'b1;
      goto(23); clr_status = 1'b0;
      goto(46); clr_status = 1'b1;
      goto(48); clr_status = 1'b0;
      goto(470);
      drain("r2");

      // Run 3: a one-clock lock glitch during STABLE restarts the stability window.
      exp_ev(-1, HOLDV, 1'b0, 4'd0, "r3_reset");
      exp_ev( 4, WAITV, 1'b0, 4'd0, "r3_resetb_rise");
      exp_ev(19, RELV,  1'b0, 4'd0, "r3_delayed_early_fall");
      exp_ev(22, RUNV,  1'b0, 4'd0, "r3_delayed_ready");
      pll_lock = 1'b1;
      do_reset();
      goto(6); pll_lock = 1'b0;
      goto(7); pll_lock = 1'b1;
      goto(30);
      drain("r3");

      // Run 4: lock_s rises on the same clock as the timeout. Lock wins and
      // no retry is counted.
      exp_ev(-1, HOLDV, 1'b0, 4'd0, "r4_reset");
      exp_ev( 4, WAITV, 1'b0, 4'd0, "r4_resetb_rise");
      exp_ev(32, RELV,  1'b0, 4'd0, "r4_lock_at_timeout_release");
      exp_ev(35, RUNV,  1'b0, 4'd0, "r4_lock_at_timeout_ready");
      pll_lock = 1'b0;
      do_reset();
      goto(20); pll_lock = 1'b1;
      goto(40);
      drain("r4");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
